// File: rtl/decoder_stream.sv
// Streaming binary-to-one-hot decoder: codes enter through a small FIFO and leave
// as one-hot words on a valid/ready port, with a count of delivered words.
module decoder_stream #(
    parameter int IN_W  = 3,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [IN_W-1:0]        in_code,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [(1<<IN_W)-1:0]   out_onehot,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       dec_count,
    output logic                   count_wrap
);

    localparam int OUT_W = 1 << IN_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [IN_W-1:0]  mem_q [DEPTH];
    logic [IN_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             push, pop;

    // in_ready depends only on registered occupancy and clear, never on out_ready.
    assign in_ready  = (occ_q < FULL_OCC) && !clear;
    assign out_valid = (occ_q != '0);
    assign push      = in_valid && in_ready;
    // A pop coinciding with clear is discarded: the flush wins.
    assign pop       = out_valid && out_ready && !clear;

    assign dec_count  = cnt_q;
    assign count_wrap = wrap_q;

    always_comb begin
        out_onehot = '0;
        if (out_valid) begin
            out_onehot[mem_q[rd_ptr_q]] = 1'b1;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        wrap_d   = wrap_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            cnt_d    = '0;
            wrap_d   = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_code;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (&cnt_q) begin
                    wrap_d = 1'b1;
                end
            end
            if (push && !pop) begin
                occ_d = occ_q + 1'b1;
            end else if (pop && !push) begin
                occ_d = occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
        end
    end

endmodule

// File: tb/tb_decoder_stream.sv
// Self-checking bench for decoder_stream: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_decoder_stream;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [2:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_onehot;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dec_count;
    logic       count_wrap;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, delivered-word count, sticky wrap flag.
    logic [2:0] exp_q[$];
    int         exp_cnt  = 0;
    logic       exp_wrap = 1'b0;

    decoder_stream #(.IN_W(3), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dec_count  (dec_count),
        .count_wrap (count_wrap)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_cnt  = 0;
        exp_wrap = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic clr);
        logic [7:0] want_hot;
        want_hot = 8'h00;
        if (exp_q.size() > 0) want_hot = 8'h01 << exp_q[0];
        chk({tag, ".in_ready"},   in_ready,   (exp_q.size() < DEPTH) && !clr);
        chk({tag, ".out_valid"},  out_valid,  exp_q.size() > 0);
        chk({tag, ".out_onehot"}, out_onehot, want_hot);
        chk({tag, ".dec_count"},  dec_count,  exp_cnt);
        chk({tag, ".count_wrap"}, count_wrap, exp_wrap);
    endtask

    // Driver: apply inputs just after a rising edge, check mid-cycle, advance the model.
    task automatic cycle(input string tag, input logic iv, input logic [2:0] code,
                         input logic ordy, input logic clr);
        logic do_push, do_pop;
        in_valid  = iv;
        in_code   = code;
        out_ready = ordy;
        clear     = clr;
        @(negedge clk);
        check_outputs(tag, clr);
        do_push = iv && (exp_q.size() < DEPTH) && !clr;
        do_pop  = ordy && (exp_q.size() > 0) && !clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            if (do_pop) begin
                void'(exp_q.pop_front());
                exp_cnt = (exp_cnt + 1) % 256;
                if (exp_cnt == 0) exp_wrap = 1'b1;
            end
            if (do_push) exp_q.push_back(code);
        end
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_code   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid",  out_valid,  1'b0);
        chk("reset.out_onehot", out_onehot, 8'h00);
        chk("reset.in_ready",   in_ready,   1'b1);
        chk("reset.dec_count",  dec_count,  8'h00);
        chk("reset.count_wrap", count_wrap, 1'b0);
        rst = 1'b0;
        model_reset();

        // 1: single code, one-cycle latency
        cycle("t1.push", 1'b1, 3'd3, 1'b0, 1'b0);
        #2;
        chk("t1.onehot_08", out_onehot, 8'h08);
        chk("t1.valid",     out_valid,  1'b1);
        cycle("t1.pop", 1'b0, 3'd0, 1'b1, 1'b0);

        // 2: backpressure fills FIFO, third code held off, then drain in order
        cycle("t2.p5",   1'b1, 3'd5, 1'b0, 1'b0);
        cycle("t2.p6",   1'b1, 3'd6, 1'b0, 1'b0);
        cycle("t2.held", 1'b1, 3'd7, 1'b0, 1'b0);
        chk("t2.full_in_ready", in_ready, 1'b0);
        chk("t2.head_20",       out_onehot, 8'h20);
        cycle("t2.d0", 1'b0, 3'd0, 1'b1, 1'b0);
        chk("t2.head_40",       out_onehot, 8'h40);
        cycle("t2.d1", 1'b0, 3'd0, 1'b1, 1'b0);
        cycle("t2.d2", 1'b0, 3'd0, 1'b1, 1'b0);
        chk("t2.count", dec_count, 8'd3);

        // 3: streaming 0..7 with out_ready held high
        for (int i = 0; i < 8; i++) cycle("t3.stream", 1'b1, 3'(i), 1'b1, 1'b0);
        cycle("t3.drain", 1'b0, 3'd0, 1'b1, 1'b0);
        chk("t3.count", dec_count, 8'd11);

        // 4: push+pop at occupancy 1
        cycle("t4.a", 1'b1, 3'd2, 1'b0, 1'b0);
        cycle("t4.b", 1'b1, 3'd4, 1'b1, 1'b0);
        cycle("t4.c", 1'b1, 3'd1, 1'b1, 1'b0);
        cycle("t4.d", 1'b0, 3'd0, 1'b1, 1'b0);
        cycle("t4.e", 1'b0, 3'd0, 1'b0, 1'b0);

        // 5: clear while full with concurrent push and pop
        cycle("t5.f0",  1'b1, 3'd0, 1'b0, 1'b0);
        cycle("t5.f1",  1'b1, 3'd7, 1'b0, 1'b0);
        cycle("t5.clr", 1'b1, 3'd4, 1'b1, 1'b1);
        chk("t5.valid_after_clear", out_valid, 1'b0);
        chk("t5.count_after_clear", dec_count, 8'd0);
        cycle("t5.idle", 1'b0, 3'd0, 1'b1, 1'b0);

        // 6: 256 pops wrap the counter
        for (int i = 0; i < 256; i++) cycle("t6.stream", 1'b1, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
        cycle("t6.drain", 1'b0, 3'd0, 1'b1, 1'b0);
        cycle("t6.idle",  1'b0, 3'd0, 1'b1, 1'b0);
        chk("t6.count_zero", dec_count,  8'd0);
        chk("t6.wrap_set",   count_wrap, 1'b1);

        // async reset mid-stream, checked before any clock edge
        cycle("t6.r0", 1'b1, 3'd6, 1'b0, 1'b0);
        cycle("t6.r1", 1'b1, 3'd1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_async.out_valid",  out_valid,  1'b0);
        chk("rst_async.out_onehot", out_onehot, 8'h00);
        chk("rst_async.in_ready",   in_ready,   1'b1);
        chk("rst_async.dec_count",  dec_count,  8'h00);
        chk("rst_async.count_wrap", count_wrap, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  1'($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
